// File: rtl/alu_mult_seq.sv
// Sequential 16x16 shift-add multiplier that borrows the pipeline's execute ALU.
// While running it stalls the pipeline and uses the ALU to accumulate partial products.
module alu_mult_seq #(
    parameter logic [3:0] OP_ADD = 4'b0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    input  logic [15:0] pipeInA,
    input  logic [15:0] pipeInB,
    input  logic [3:0]  pipeOp,
    input  logic        pipeInvA,
    input  logic        pipeInvB,
    input  logic        pipeCin,
    input  logic [15:0] aluOut,
    output logic [15:0] aluInA,
    output logic [15:0] aluInB,
    output logic [3:0]  aluOp,
    output logic        aluInvA,
    output logic        aluInvB,
    output logic        aluCin,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]  state_r, state_s;
    logic [15:0] acc_r, acc_s;
    logic [15:0] mcand_r, mcand_s;
    logic [15:0] mplier_r, mplier_s;
    logic [3:0]  count_r, count_s;
    logic [15:0] product_r, product_s;
    logic        done_r, done_s;

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        mcand_s   = mcand_r;
        mplier_s  = mplier_r;
        count_s   = count_r;
        product_s = product_r;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mcand_s  = opA;
                    mplier_s = opB;
                    acc_s    = 16'h0000;
                    count_s  = 4'd0;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // ALU currently computes acc + mcand; keep it only when this multiplier bit is set
                if (mplier_r[0]) begin
                    acc_s = aluOut;
                end else begin
                    acc_s = acc_r;
                end
                mcand_s  = {mcand_r[14:0], 1'b0};
                mplier_s = {1'b0, mplier_r[15:1]};
                count_s  = count_r + 4'd1;
                if (count_r == 4'd15) begin
                    product_s = acc_s;
                    done_s    = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            acc_r     <= 16'h0000;
            mcand_r   <= 16'h0000;
            mplier_r  <= 16'h0000;
            count_r   <= 4'd0;
            product_r <= 16'h0000;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            mcand_r   <= mcand_s;
            mplier_r  <= mplier_s;
            count_r   <= count_s;
            product_r <= product_s;
            done_r    <= done_s;
        end
    end

    // ALU control mux: sequencer owns the ALU only while running
    always_comb begin
        if (state_r == ST_RUN) begin
            aluInA  = acc_r;
            aluInB  = mcand_r;
            aluOp   = OP_ADD;
            aluInvA = 1'b0;
            aluInvB = 1'b0;
            aluCin  = 1'b0;
        end else begin
            aluInA  = pipeInA;
            aluInB  = pipeInB;
            aluOp   = pipeOp;
            aluInvA = pipeInvA;
            aluInvB = pipeInvB;
            aluCin  = pipeCin;
        end
    end

    assign stall   = (state_r == ST_RUN);
    assign busy    = (state_r == ST_RUN) || (state_r == ST_DONE);
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed testbench for alu_mult_seq with a behavioural model of the shared ALU.
module tb_alu_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] opA, opB;
    logic [15:0] pipeInA, pipeInB;
    logic [3:0]  pipeOp;
    logic        pipeInvA, pipeInvB, pipeCin;
    logic [15:0] aluOut;
    logic [15:0] aluInA, aluInB;
    logic [3:0]  aluOp;
    logic        aluInvA, aluInvB, aluCin;
    logic        stall, busy, done;
    logic [15:0] product;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] last_prod = 16'h0000;
    logic [15:0] ain_s, bin_s;

    alu_mult_seq #(.OP_ADD(4'b0100)) dut (
        .clk(clk), .rst(rst), .start(start), .opA(opA), .opB(opB),
        .pipeInA(pipeInA), .pipeInB(pipeInB), .pipeOp(pipeOp),
        .pipeInvA(pipeInvA), .pipeInvB(pipeInvB), .pipeCin(pipeCin),
        .aluOut(aluOut), .aluInA(aluInA), .aluInB(aluInB), .aluOp(aluOp),
        .aluInvA(aluInvA), .aluInvB(aluInvB), .aluCin(aluCin),
        .stall(stall), .busy(busy), .done(done), .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared execute ALU: add for opcode 0100, AND otherwise
    assign ain_s  = aluInvA ? ~aluInA : aluInA;
    assign bin_s  = aluInvB ? ~aluInB : aluInB;
    assign aluOut = (aluOp == 4'b0100) ? (ain_s + bin_s + {15'd0, aluCin}) : (ain_s & bin_s);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Cycle 0 = negedge where start is raised; checks through cycle 17 (done)
    task automatic run_mult(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] expv, input bit repulse);
        @(negedge clk);
        check1("c0_busy", busy, 1'b0);
        check1("c0_done", done, 1'b0);
        check("c0_prod_hold", product, last_prod);
        opA = a; opB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; opA = 16'hDEAD; opB = 16'hBEEF;
        check("c1_ina_acc0", aluInA, 16'h0000);
        check("c1_inb_mcand", aluInB, a);
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) @(negedge clk);
            check1("run_stall", stall, 1'b1);
            check1("run_busy", busy, 1'b1);
            check1("run_done", done, 1'b0);
            check("run_op", {12'd0, aluOp}, 16'h0004);
            check1("run_cin", aluCin, 1'b0);
            if (repulse && c == 5) begin
                start = 1'b1; opA = 16'h0007; opB = 16'h0007;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check1("c17_done", done, 1'b1);
        check1("c17_stall", stall, 1'b0);
        check1("c17_busy", busy, 1'b1);
        check("c17_product", product, expv);
        check("c17_pass_ina", aluInA, 16'h1234);
        last_prod = expv;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; opA = 16'h0000; opB = 16'h0000;
        pipeInA = 16'h1234; pipeInB = 16'h0001; pipeOp = 4'h3;
        pipeInvA = 1'b0; pipeInvB = 1'b0; pipeCin = 1'b1;
        #1;
        check1("rst_stall", stall, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check("rst_product", product, 16'h0000);
        check("rst_pass_ina", aluInA, 16'h1234);
        @(negedge clk);
        rst = 1'b1;

        // IDLE pass-through
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ina", aluInA, 16'h1234);
            check("idle_inb", aluInB, 16'h0001);
            check("idle_op", {12'd0, aluOp}, 16'h0003);
            check1("idle_cin", aluCin, 1'b1);
            check1("idle_inva", aluInvA, 1'b0);
            check1("idle_stall", stall, 1'b0);
        end

        run_mult(16'h0003, 16'h0005, 16'h000F, 1'b0);
        run_mult(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);   // back-to-back start in cycle 18
        run_mult(16'h0100, 16'h0100, 16'h0000, 1'b0);
        run_mult(16'h0003, 16'h0005, 16'h000F, 1'b1);   // re-pulse ignored
        run_mult(16'h0006, 16'h0007, 16'h002A, 1'b0);

        // Abort mid-run with reset in cycle 8
        @(negedge clk);
        opA = 16'h0005; opB = 16'h0003; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check1("abort_c1_stall", stall, 1'b1);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check1("abort_stall", stall, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", done, 1'b0);
        check("abort_product", product, 16'h0000);
        check1("abort_pass_cin", aluCin, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("abort_no_done", done, 1'b0);
            check("abort_prod_held0", product, 16'h0000);
        end
        rst = 1'b1;
        last_prod = 16'h0000;
        run_mult(16'h0002, 16'h0009, 16'h0012, 1'b0);

        @(negedge clk);
        check1("final_done_low", done, 1'b0);
        check("final_prod_hold", product, 16'h0012);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mult_seq.md
ALU_MULT_SEQ -- requirements
Module: alu_mult_seq

Interface
REQ-001 Parameter: OP_ADD, default 4'b0100, ALU opcode selecting 16-bit add.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle multiply request, sampled only in IDLE.
REQ-005 opA, opB  in  16 each  multiplicand and multiplier, sampled with accepted start.
REQ-006 pipeInA, pipeInB  in  16 each; pipeOp  in  4; pipeInvA, pipeInvB, pipeCin  in  1 each: pipeline's normal ALU controls.
REQ-007 aluOut  in  16  result returned by the shared execute ALU.
REQ-008 aluInA, aluInB  out  16 each; aluOp  out  4; aluInvA, aluInvB, aluCin  out  1 each: controls driven to the shared ALU.
REQ-009 stall  out  1  holds the pipeline while the sequencer owns the ALU.
REQ-010 busy  out  1  high in RUN or DONE.
REQ-011 done  out  1  one-cycle pulse, product valid.
REQ-012 product  out  16  low 16 bits of opA*opB (unsigned).

Function
REQ-013 FSM states: IDLE, RUN, DONE; registered, 2-bit encoding.
REQ-014 IDLE & start: latch mcand=opA, mplier=opB, acc=0, count=0; go RUN next edge.
REQ-015 IDLE & !start: remain IDLE; no register change.
REQ-016 RUN: drive aluInA=acc, aluInB=mcand, aluOp=OP_ADD, aluInvA=aluInvB=aluCin=0.
REQ-017 RUN each edge: if mplier[0]=1, acc<=aluOut, else acc unchanged; mcand<=mcand<<1 (zero fill, bit 15 discarded); mplier<=mplier>>1 (zero fill); count<=count+1.
REQ-018 RUN exactly 16 cycles, no early exit on mplier=0; edge with count=15 moves to DONE.
REQ-019 DONE: done=1 for one cycle, product=acc; next edge to IDLE.
REQ-020 product register loads on RUN->DONE edge and holds until next completion or reset.
REQ-021 Latency: start high in cycle 0 -> RUN cycles 1..16 -> done high in cycle 17.
REQ-022 stall=1 exactly when state=RUN; combinational from state.
REQ-023 IDLE and DONE: ALU outputs are combinational pass-through of pipe* inputs.
REQ-024 start in RUN or DONE is ignored; no queueing; operands not resampled.
REQ-025 Arithmetic modulo 2^16; overflow bits above bit 15 discarded, no flag.
REQ-026 Operand changes on opA/opB after acceptance have no effect.
REQ-027 No combinational path from aluOut to any output.

Reset
REQ-028 rst low: state=IDLE, acc, mcand, mplier, count, product=0 immediately, without clock.
REQ-029 Reset outputs: stall=0, busy=0, done=0, product=0, ALU outputs pass-through.
REQ-030 rst asserted mid-RUN aborts operation; no done pulse, product=0.
REQ-031 First start sampled on first rising edge after rst deasserts.

Verification
REQ-032 opA=3, opB=5, start 1 cycle -> stall high cycles 1..16, done in cycle 17, product=0x000F.
REQ-033 opA=0xFFFF, opB=0xFFFF -> product=0x0001; opA=0x0100, opB=0x0100 -> product=0x0000 (wrap).
REQ-034 start re-pulsed in cycle 5 of RUN with opA=7, opB=7 -> ignored; first result delivered unchanged in cycle 17.
REQ-035 rst low in cycle 8 of RUN -> stall, busy, product=0 same cycle; no done; subsequent 2*9 yields 0x0012.
REQ-036 IDLE with pipeInA=0x1234, pipeInB=0x0001, pipeOp=0x3, pipeCin=1 -> ALU outputs equal these values every cycle, stall=0.
REQ-037 Back-to-back: start in cycle 18 (first IDLE after done) -> accepted, second done in cycle 35.
